jstk_xfer_ctrl: RTL
===================

Name: jstk_xfer_ctrl

Overview:
Transaction controller that sits directly upstream of the SPI mode-0 byte engine, on the same 66.67 kHz serial clock. Each request runs one complete 5-byte PmodJSTK packet:
- drives slave select;
- sequences five byte transfers through the engine's sndRec/BUSY handshake, with required setup and inter-byte gaps;
- assembles the received bytes into joystick X/Y positions and button state for the game logic.

Parameters:
SETUP_CYCLES, 1, CLK cycles between ss_n falling and the first byte request (>=15 us at 66.67 kHz).
GAP_CYCLES, 1, idle CLK cycles between the end of one byte and the next request.
NUM_BYTES, 5, bytes per packet (fixed by the PmodJSTK protocol; not intended to change).
TIMEOUT_CYCLES, 64, maximum cycles to wait on any single engine handshake edge.

Ports:
CLK  in  1  serial-rate clock, shared with the byte engine
RESET  in  1  synchronous, active-high reset
start  in  1  request one packet; sampled only in IDLE
led  in  2  LED command bits sent in byte 0
byte_busy  in  1  byte engine BUSY
byte_rx  in  8  byte engine DOUT (last received byte)
byte_snd_rec  out  1  byte engine sndRec request
byte_tx  out  8  byte engine DIN
ss_n  out  1  PmodJSTK slave select, active low
busy  out  1  packet in progress
done  out  1  one-cycle pulse: packet complete and outputs updated
x_pos  out  10  joystick X, 0..1023
y_pos  out  10  joystick Y, 0..1023
buttons  out  3  {btn_trigger, btn2, btn1}
timeout_err  out  1  sticky: handshake timed out; cleared by RESET or the next start

Behaviour:
- Clocking and reset:
  - Everything clocks on posedge CLK; reset is synchronous.
  - Reset values: ss_n=1, busy=0, done=0, byte_snd_rec=0, byte_tx=0x00, x_pos=0, y_pos=0, buttons=0, timeout_err=0; state=IDLE, byte index=0.
- FSM states: IDLE, SETUP, REQ, WAIT_HI, WAIT_LO, STORE, GAP, FINISH.
- IDLE:
  - ss_n=1, busy=0.
  - start=1 -> SETUP; at the same edge set ss_n=0, busy=1, idx=0, clear timeout_err.
- SETUP:
  - Count SETUP_CYCLES, then go to REQ.
  - byte_tx is loaded: idx 0 -> {6'b100000, led}; idx 1..4 -> 0x00.
  - led is sampled once, on the IDLE->SETUP edge.
- REQ: byte_snd_rec=1; go to WAIT_HI.
- WAIT_HI:
  - byte_snd_rec stays 1 until byte_busy=1 is sampled; then drop it and go to WAIT_LO.
- WAIT_LO: wait for byte_busy=0; then go to STORE.
- STORE:
  - Capture byte_rx into rx[idx].
  - If idx==NUM_BYTES-1 -> FINISH; else idx+1, reload byte_tx, go to GAP.
- GAP: count GAP_CYCLES, then go to REQ.
- FINISH:
  - ss_n=1, busy=0, done=1 for exactly one cycle; go to IDLE.
  - Output registers update on this same edge:
    - x_pos = {rx[1][1:0], rx[0]}
    - y_pos = {rx[3][1:0], rx[2]}
    - buttons = rx[4][2:0]
  - Upper bits of rx[1], rx[3] and rx[4] are ignored.
- Output holding:
  - x_pos, y_pos and buttons hold their last values between packets.
  - They never show a partially assembled packet.
- Timeout:
  - In WAIT_HI or WAIT_LO, a counter reset on state entry reaches TIMEOUT_CYCLES -> set timeout_err=1, drop byte_snd_rec, ss_n=1, go to IDLE.
  - No done pulse; outputs are left unchanged.
- start while busy is ignored; there is no queueing.
- Reset mid-packet: the next cycle shows reset values, ss_n=1, and no done pulse.
- Nominal packet latency from start to done ≈ 1 + SETUP + 5*(engine byte time + 1) + 4*GAP cycles.

Decomposition:
- Shared package jstk_pkg holds:
  - state encoding;
  - JSTK_CMD_LED=6'b100000;
  - NUM_BYTES;
  - the byte-field index constants (X_LO=0, X_HI=1, Y_LO=2, Y_HI=3, BTN=4).
- One natural sub-module: jstk_packet_unpack. It is purely the registered rx[0..4] -> x/y/buttons assembly, so the FSM stays handshake-only.
- The bench instantiates this block together with the existing byte engine and a behavioural PmodJSTK slave model.

Test Plan:
- Nominal packet:
  - Stimulus: slave returns bytes 0x2C,0x02,0xFF,0x03,0x05; led=2'b01.
  - Required: byte 0 sent on MOSI = 0x81, bytes 1..4 = 0x00; done pulses once; x_pos=0x22C, y_pos=0x3FF, buttons=3'b101; ss_n low for the whole packet.
- Masking:
  - Stimulus: slave returns 0xFF,0xFF,0x00,0xFC,0xF8.
  - Required: x_pos=0x3FF, y_pos=0x000, buttons=3'b000.
- Back-to-back packets:
  - Stimulus: start held high continuously.
  - Required: second packet begins only after done; ss_n returns to 1 for >=1 cycle between packets; start pulses while busy=1 produce no extra packets.
- Timeout:
  - Stimulus: byte_busy forced to 0.
  - Required: after TIMEOUT_CYCLES in WAIT_HI, timeout_err=1, ss_n=1, no done, x_pos unchanged; the next start clears timeout_err.
- Reset mid-packet:
  - Stimulus: RESET asserted during byte 2.
  - Required: next cycle ss_n=1, busy=0, byte_snd_rec=0, all outputs zero; a following start completes normally.
- Gap timing:
  - Stimulus: GAP_CYCLES=3.
  - Required: measured cycles from each byte_busy falling edge to the next byte_snd_rec rising edge equals 4 (STORE + 3 GAP).

Source files
------------

// File: rtl/jstk_pkg.sv
// rtl/jstk_pkg.sv - shared PmodJSTK packet constants, FSM encoding and command helper
package jstk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_REQ,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_STORE,
        ST_GAP,
        ST_FINISH
    } jstk_state_e;

    localparam int             JSTK_NUM_BYTES = 5;
    localparam int             IDX_W          = 3;
    localparam logic [5:0]     JSTK_CMD_LED   = 6'b100000;

    localparam logic [IDX_W-1:0] X_LO = 3'd0;
    localparam logic [IDX_W-1:0] X_HI = 3'd1;
    localparam logic [IDX_W-1:0] Y_LO = 3'd2;
    localparam logic [IDX_W-1:0] Y_HI = 3'd3;
    localparam logic [IDX_W-1:0] BTN  = 3'd4;

    // Only the first byte carries the LED command; the rest are dummy 0x00 clocks.
    function automatic logic [7:0] tx_byte(input logic [IDX_W-1:0] idx, input logic [1:0] led);
        return (idx == X_LO) ? {JSTK_CMD_LED, led} : 8'h00;
    endfunction

endpackage

// File: rtl/jstk_packet_unpack.sv
// rtl/jstk_packet_unpack.sv - holds received packet bytes and publishes X/Y/buttons on commit
module jstk_packet_unpack
    import jstk_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             cap_en_i,
    input  logic [IDX_W-1:0] cap_idx_i,
    input  logic [7:0]       byte_rx_i,
    input  logic             commit_i,
    output logic [9:0]       x_pos_o,
    output logic [9:0]       y_pos_o,
    output logic [2:0]       buttons_o
);

    // Only the meaningful bits of each byte are kept; upper bits are discarded at capture.
    logic [7:0] x_lo_q, y_lo_q;
    logic [1:0] x_hi_q, y_hi_q;
    logic [2:0] btn_q;
    logic [9:0] x_pos_q, y_pos_q;
    logic [2:0] buttons_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            x_lo_q    <= '0;
            x_hi_q    <= '0;
            y_lo_q    <= '0;
            y_hi_q    <= '0;
            btn_q     <= '0;
            x_pos_q   <= '0;
            y_pos_q   <= '0;
            buttons_q <= '0;
        end else begin
            if (cap_en_i) begin
                case (cap_idx_i)
                    X_LO:    x_lo_q <= byte_rx_i;
                    X_HI:    x_hi_q <= byte_rx_i[1:0];
                    Y_LO:    y_lo_q <= byte_rx_i;
                    Y_HI:    y_hi_q <= byte_rx_i[1:0];
                    BTN:     btn_q  <= byte_rx_i[2:0];
                    default: ;
                endcase
            end
            if (commit_i) begin
                x_pos_q   <= {x_hi_q, x_lo_q};
                y_pos_q   <= {y_hi_q, y_lo_q};
                buttons_q <= btn_q;
            end
        end
    end

    assign x_pos_o   = x_pos_q;
    assign y_pos_o   = y_pos_q;
    assign buttons_o = buttons_q;

endmodule

// File: rtl/jstk_xfer_ctrl.sv
// rtl/jstk_xfer_ctrl.sv - sequences one 5-byte PmodJSTK packet through the SPI byte engine
module jstk_xfer_ctrl
    import jstk_pkg::*;
#(
    parameter int SETUP_CYCLES   = 1,
    parameter int GAP_CYCLES     = 1,
    parameter int NUM_BYTES      = JSTK_NUM_BYTES,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       start,
    input  logic [1:0] led,
    input  logic       byte_busy,
    input  logic [7:0] byte_rx,
    output logic       byte_snd_rec,
    output logic [7:0] byte_tx,
    output logic       ss_n,
    output logic       busy,
    output logic       done,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [2:0] buttons,
    output logic       timeout_err
);

    localparam int               CW         = 16;
    localparam logic [CW-1:0]    SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0]    GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0]    TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BYTES - 1);

    jstk_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ss_n_q, ss_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             snd_q, snd_d;
    logic [7:0]       tx_q, tx_d;
    logic             terr_q, terr_d;
    logic [IDX_W-1:0] idx_inc;

    assign idx_inc = idx_q + 1'b1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            ss_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            snd_q   <= 1'b0;
            tx_q    <= 8'h00;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ss_n_q  <= ss_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            snd_q   <= snd_d;
            tx_q    <= tx_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CW'(1);
        ss_n_d  = ss_n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        snd_d   = snd_q;
        tx_d    = tx_q;
        terr_d  = terr_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = ST_SETUP;
                    ss_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    terr_d  = 1'b0;
                    tx_d    = tx_byte('0, led);
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_REQ;
                    snd_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT_HI;
                cnt_d   = '0;
            end
            ST_WAIT_HI, ST_WAIT_LO: begin
                if ((state_q == ST_WAIT_HI) && byte_busy) begin
                    state_d = ST_WAIT_LO;
                    snd_d   = 1'b0;
                    cnt_d   = '0;
                end else if ((state_q == ST_WAIT_LO) && !byte_busy) begin
                    state_d = ST_STORE;
                end else if (cnt_q == TO_LAST) begin
                    // Abandon the packet: release the slave without touching published outputs.
                    state_d = ST_IDLE;
                    terr_d  = 1'b1;
                    snd_d   = 1'b0;
                    ss_n_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_STORE: begin
                cnt_d = '0;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_GAP;
                    idx_d   = idx_inc;
                    tx_d    = tx_byte(idx_inc, 2'b00);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_REQ;
                    snd_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                ss_n_d  = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    jstk_packet_unpack u_unpack (
        .CLK       (CLK),
        .RESET     (RESET),
        .cap_en_i  (state_q == ST_STORE),
        .cap_idx_i (idx_q),
        .byte_rx_i (byte_rx),
        .commit_i  (state_q == ST_FINISH),
        .x_pos_o   (x_pos),
        .y_pos_o   (y_pos),
        .buttons_o (buttons)
    );

    assign byte_snd_rec = snd_q;
    assign byte_tx      = tx_q;
    assign ss_n         = ss_n_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timeout_err  = terr_q;

endmodule
